alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 138 +++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command/response bundle for alu_seq: valid/ready command channel in,
// valid/ready result channel out.
interface alu_seq_if #(
   parameter int DataWidth     = 8,
   parameter int NumOpCodeBits = 5,
   parameter int ParamBits     = 8,
   parameter int NumStatusBits = 3
);
   logic                     in_valid;
   logic                     in_ready;
   logic [NumOpCodeBits-1:0] opcode;
   logic [DataWidth-1:0]     operand1;
   logic [DataWidth-1:0]     operand2;
   logic [ParamBits-1:0]     param;
   logic                     out_valid;
   logic                     out_ready;
   logic [DataWidth-1:0]     result;
   logic [NumStatusBits-1:0] status;
   logic                     op_error;

   modport master (
      output in_valid, opcode, operand1, operand2, param, out_ready,
      input  in_ready, out_valid, result, status, op_error
   );

   modport slave (
      input  in_valid, opcode, operand1, operand2, param, out_ready,
      output in_ready, out_valid, result, status, op_error
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish one cycle after accept, shifts move
// one bit per cycle. Status = {zero, underflow, carry}.
module alu_seq #(
   parameter int DataWidth     = 8,
   parameter int NumOpCodeBits = 5,
   parameter int ParamBits     = 8,
   parameter int NumStatusBits = 3
) (
   input logic      i_clock,
   input logic      i_reset,
   alu_seq_if.slave bus
);
   localparam int CntW = $clog2(DataWidth + 1);

   localparam logic [NumOpCodeBits-1:0] OP_NOP = NumOpCodeBits'(0);
   localparam logic [NumOpCodeBits-1:0] OP_ADD = NumOpCodeBits'(1);
   localparam logic [NumOpCodeBits-1:0] OP_SUB = NumOpCodeBits'(2);
   localparam logic [NumOpCodeBits-1:0] OP_AND = NumOpCodeBits'(3);
   localparam logic [NumOpCodeBits-1:0] OP_OR  = NumOpCodeBits'(4);
   localparam logic [NumOpCodeBits-1:0] OP_NOT = NumOpCodeBits'(5);
   localparam logic [NumOpCodeBits-1:0] OP_XOR = NumOpCodeBits'(6);
   localparam logic [NumOpCodeBits-1:0] OP_SHL = NumOpCodeBits'(7);
   localparam logic [NumOpCodeBits-1:0] OP_SHR = NumOpCodeBits'(8);
   localparam logic [NumOpCodeBits-1:0] OP_VAL = NumOpCodeBits'(9);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                   r_state;
   logic [DataWidth-1:0]     r_result;
   logic [NumStatusBits-1:0] r_status;
   logic                     r_err;
   logic                     r_out_valid;
   logic                     r_dir;
   logic [CntW-1:0]          r_cnt;

   logic [DataWidth:0]       w_sum;
   logic [DataWidth-1:0]     w_res;
   logic [DataWidth-1:0]     w_shifted;
   logic [NumStatusBits-1:0] w_status;
   logic                     w_carry;
   logic                     w_under;
   logic                     w_zero_en;
   logic                     w_err;
   logic                     w_is_shift;
   logic                     w_bit_out;
   logic [CntW-1:0]          w_n;

   assign w_sum      = {1'b0, bus.operand1} + {1'b0, bus.operand2};
   assign w_is_shift = (bus.opcode == OP_SHL) || (bus.opcode == OP_SHR);
   assign w_n        = (32'(bus.param) >= DataWidth) ? CntW'(DataWidth)
                                                     : CntW'(bus.param);

   // Shift ops land here only when the effective amount is zero.
   always_comb begin
      w_res     = '0;
      w_carry   = 1'b0;
      w_under   = 1'b0;
      w_zero_en = 1'b1;
      w_err     = 1'b0;
      case (bus.opcode)
         OP_NOP: w_zero_en = 1'b0;
         OP_ADD: begin
            w_res   = w_sum[DataWidth-1:0];
            w_carry = w_sum[DataWidth];
         end
         OP_SUB: begin
            w_res   = bus.operand1 - bus.operand2;
            w_under = bus.operand2 > bus.operand1;
         end
         OP_AND:         w_res = bus.operand1 & bus.operand2;
         OP_OR:          w_res = bus.operand1 | bus.operand2;
         OP_NOT:         w_res = ~bus.operand2;
         OP_XOR:         w_res = bus.operand1 ^ bus.operand2;
         OP_SHL, OP_SHR: w_res = bus.operand1;
         OP_VAL:         w_res = DataWidth'(bus.param);
         default: begin
            w_zero_en = 1'b0;
            w_err     = 1'b1;
         end
      endcase
   end

   assign w_status  = NumStatusBits'({w_zero_en && (w_res == '0), w_under, w_carry});
   assign w_shifted = r_dir ? (r_result >> 1) : (r_result << 1);
   assign w_bit_out = r_dir ? r_result[0] : r_result[DataWidth-1];

   assign bus.in_ready  = (r_state == IDLE) && !i_reset;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.status    = r_status;
   assign bus.op_error  = r_err;

   // r_result doubles as the shift register; status is written only on the last step.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_result    <= '0;
         r_status    <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_dir       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               if (w_is_shift && (w_n != '0)) begin
                  r_result <= bus.operand1;
                  r_cnt    <= w_n;
                  r_dir    <= (bus.opcode == OP_SHR);
                  r_status <= '0;
                  r_err    <= 1'b0;
                  r_state  <= SHIFT;
               end else begin
                  r_result    <= w_res;
                  r_status    <= w_status;
                  r_err       <= w_err;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            SHIFT: begin
               r_result <= w_shifted;
               r_cnt    <= r_cnt - CntW'(1);
               if (r_cnt == CntW'(1)) begin
                  r_status    <= NumStatusBits'({w_shifted == '0, 1'b0, w_bit_out});
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: if (bus.out_ready) begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq at DataWidth 8 and 16, with
// per-instance scoreboards checked by negedge monitors.
module tb_alu_seq;
   typedef struct {
      logic [31:0] res;
      logic [2:0]  st;
      logic        err;
      int          lat;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   rnd_rdy = 1'b0;
   bit   force_rdy = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_seq_if #(.DataWidth(8))  b8 ();
   alu_seq_if #(.DataWidth(16)) b16 ();

   alu_seq #(.DataWidth(8))  dut8  (.i_clock(clk), .i_reset(rst), .bus(b8));
   alu_seq #(.DataWidth(16)) dut16 (.i_clock(clk), .i_reset(rst), .bus(b16));

   exp_t q8[$];
   exp_t q16[$];
   exp_t c8, c16;
   bit   a8 = 1'b0;
   bit   a16 = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Reference: direct arithmetic on wide integers, then mask to width w.
   function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  input int p, input int w);
      exp_t        e;
      logic [32:0] s;
      logic [31:0] m;
      int          n;
      logic        c, u;
      m = (32'd1 << w) - 32'd1;
      e.res = '0; e.st = '0; e.err = 1'b0; e.lat = 1; e.due = 0;
      c = 1'b0; u = 1'b0;
      n = (p < w) ? p : w;
      case (op)
         0: return e;
         1: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0] & m; c = s[w]; end
         2: begin e.res = (a - b) & m; u = (b > a); end
         3: e.res = a & b;
         4: e.res = a | b;
         5: e.res = ~b & m;
         6: e.res = a ^ b;
         7: begin e.res = (a << n) & m; c = (n > 0) ? a[w-n] : 1'b0; e.lat = 1 + n; end
         8: begin e.res = a >> n; c = (n > 0) ? a[n-1] : 1'b0; e.lat = 1 + n; end
         9: e.res = 32'(p) & m;
         default: begin e.err = 1'b1; return e; end
      endcase
      e.st = {e.res == 32'd0, u, c};
      return e;
   endfunction

   always @(posedge clk) begin
      #2;
      b8.out_ready = rnd_rdy ? (($urandom % 4) != 0) : force_rdy;
   end

   always @(negedge clk) begin
      if (rst || !b8.out_valid) a8 = 1'b0;
      else begin
         if (!a8) begin
            if (q8.size() == 0) chk("spurious_out_valid8", 32'(b8.out_valid), 32'd0);
            else begin
               c8 = q8.pop_front();
               chk("latency8", 32'(cyc), 32'(c8.due));
               a8 = 1'b1;
            end
         end
         if (a8) begin
            chk("result8", 32'(b8.result), c8.res);
            chk("status8", 32'(b8.status), 32'(c8.st));
            chk("op_error8", 32'(b8.op_error), 32'(c8.err));
         end
         chk("in_ready_busy8", 32'(b8.in_ready), 32'd0);
         if (b8.out_ready) a8 = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst || !b16.out_valid) a16 = 1'b0;
      else begin
         if (!a16) begin
            if (q16.size() == 0) chk("spurious_out_valid16", 32'(b16.out_valid), 32'd0);
            else begin
               c16 = q16.pop_front();
               chk("latency16", 32'(cyc), 32'(c16.due));
               a16 = 1'b1;
            end
         end
         if (a16) begin
            chk("result16", 32'(b16.result), c16.res);
            chk("status16", 32'(b16.status), 32'(c16.st));
            chk("op_error16", 32'(b16.op_error), 32'(c16.err));
         end
         if (b16.out_ready) a16 = 1'b0;
      end
   end

   task automatic send(input bit w16, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] p, input exp_t e, input bit push);
      int tmo = 0;
      @(negedge clk);
      if (w16) begin
         b16.opcode = op; b16.operand1 = a[15:0]; b16.operand2 = b[15:0];
         b16.param = p; b16.in_valid = 1'b1;
      end else begin
         b8.opcode = op; b8.operand1 = a[7:0]; b8.operand2 = b[7:0];
         b8.param = p; b8.in_valid = 1'b1;
      end
      while (!(w16 ? b16.in_ready : b8.in_ready)) begin
         @(negedge clk);
         tmo++;
         if (tmo > 400) begin
            chk("accept_timeout", 32'(tmo), 32'd0);
            break;
         end
      end
      e.due = cyc + e.lat;
      if (push) begin
         if (w16) q16.push_back(e);
         else     q8.push_back(e);
      end
      @(posedge clk);
      #1;
      b8.in_valid  = 1'b0;
      b16.in_valid = 1'b0;
   endtask

   task automatic send_rand(input bit w16);
      int          w, r, op, p;
      logic [31:0] a, b, m;
      w = w16 ? 16 : 8;
      m = w16 ? 32'hFFFF : 32'hFF;
      r = $urandom_range(0, 13);
      op = (r < 10) ? r : $urandom_range(10, 31);
      a = $urandom & m;
      b = $urandom & m;
      if (op == 7 || op == 8) p = (($urandom % 8) == 0) ? 200 : $urandom_range(0, w + 2);
      else                    p = $urandom_range(0, 255);
      send(w16, 5'(op), a, b, 8'(p), model(op, a, b, p, w), 1'b1);
   endtask

   task automatic drain();
      int t = 0;
      while ((q8.size() != 0 || a8 || q16.size() != 0 || a16) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk("drain_pending", 32'(q8.size() + q16.size() + int'(a8) + int'(a16)), 32'd0);
   endtask

   localparam int ND = 13;
   logic [4:0] d_op  [ND] = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd7, 5'd8, 5'd8, 5'b10110, 5'd7, 5'd0, 5'd9, 5'd9, 5'd5};
   logic [7:0] d_a   [ND] = '{8'hF0, 8'h80, 8'h05, 8'h33, 8'h81, 8'h81, 8'h81, 8'h12, 8'h81, 8'h05, 8'h00, 8'h00, 8'h00};
   logic [7:0] d_b   [ND] = '{8'h20, 8'h80, 8'h07, 8'h33, 8'h00, 8'h00, 8'h00, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
   logic [7:0] d_p   [ND] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd1, 8'd0, 8'd0, 8'd200, 8'd0, 8'hA5, 8'd0, 8'd0};
   logic [7:0] d_res [ND] = '{8'h10, 8'h00, 8'hFE, 8'h00, 8'h08, 8'h40, 8'h81, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
   logic [2:0] d_st  [ND] = '{3'b001, 3'b101, 3'b010, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b100, 3'b100};
   logic       d_err [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   int         d_lat [ND] = '{1, 1, 1, 1, 4, 2, 1, 1, 9, 1, 1, 1, 1};

   initial begin
      exp_t e;
      b8.in_valid = 1'b0; b8.opcode = '0; b8.operand1 = '0; b8.operand2 = '0; b8.param = '0;
      b16.in_valid = 1'b0; b16.opcode = '0; b16.operand1 = '0; b16.operand2 = '0; b16.param = '0;
      b16.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(b8.in_ready), 32'd0);
      chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
      chk("rst_result", 32'(b8.result), 32'd0);
      chk("rst_status", 32'(b8.status), 32'd0);
      chk("rst_op_error", 32'(b8.op_error), 32'd0);
      chk("rst_out_valid16", 32'(b16.out_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(b8.in_ready), 32'd1);

      for (int i = 0; i < ND; i++) begin
         e.res = 32'(d_res[i]); e.st = d_st[i]; e.err = d_err[i]; e.lat = d_lat[i]; e.due = 0;
         send(1'b0, d_op[i], 32'(d_a[i]), 32'(d_b[i]), d_p[i], e, 1'b1);
      end
      drain();

      rnd_rdy = 1'b1;
      repeat (150) send_rand(1'b0);
      drain();

      // Backpressure: hold XOR result, offer an extra command that must be ignored.
      rnd_rdy = 1'b0;
      force_rdy = 1'b0;
      repeat (2) @(posedge clk);
      e.res = 32'h00; e.st = 3'b100; e.err = 1'b0; e.lat = 1; e.due = 0;
      send(1'b0, 5'd6, 32'hAA, 32'hAA, 8'd0, e, 1'b1);
      @(negedge clk);
      b8.opcode = 5'd1; b8.operand1 = 8'h01; b8.operand2 = 8'h01; b8.in_valid = 1'b1;
      repeat (5) @(negedge clk);
      b8.in_valid = 1'b0;
      @(posedge clk);
      #1;
      force_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid_drop", 32'(b8.out_valid), 32'd0);
      chk("bp_in_ready_back", 32'(b8.in_ready), 32'd1);
      repeat (3) @(posedge clk);

      // Reset three cycles into a 6-step shift: no result may ever appear.
      e.res = 32'h0; e.st = 3'b0; e.err = 1'b0; e.lat = 7; e.due = 0;
      send(1'b0, 5'd7, 32'hFF, 32'h00, 8'd6, e, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_in_ready", 32'(b8.in_ready), 32'd0);
      chk("abort_out_valid", 32'(b8.out_valid), 32'd0);
      chk("abort_result", 32'(b8.result), 32'd0);
      chk("abort_status", 32'(b8.status), 32'd0);
      chk("abort_op_error", 32'(b8.op_error), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_in_ready_after", 32'(b8.in_ready), 32'd1);
      repeat (12) @(posedge clk);

      e.res = 32'h0000; e.st = 3'b101; e.err = 1'b0; e.lat = 1; e.due = 0;
      send(1'b1, 5'd1, 32'hFFFF, 32'h0001, 8'd0, e, 1'b1);
      e.res = 32'h0000; e.st = 3'b101; e.err = 1'b0; e.lat = 17; e.due = 0;
      send(1'b1, 5'd8, 32'h8001, 32'h0000, 8'd40, e, 1'b1);
      repeat (40) send_rand(1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
